// File: rtl/tri_setup_if.sv
// rtl/tri_setup_if.sv - triangle setup port bundle: upstream triangle in, setup data out to rasteriser
interface tri_setup_if;
  logic               tri_valid_i;
  logic               busy_o;
  logic [15:0]        v0x_i, v0y_i, v1x_i, v1y_i, v2x_i, v2y_i;
  logic [23:0]        area_o;
  logic signed [16:0] dl_w0_col_o, dl_w1_col_o, dl_w2_col_o;
  logic signed [16:0] dl_w0_row_o, dl_w1_row_o, dl_w2_row_o;
  logic signed [24:0] w0_row_o, w1_row_o, w2_row_o;
  logic [11:0]        x_min_o, y_min_o, x_max_o, y_max_o;
  logic               valid_o;
  logic               busy_i;
  logic               culled_o;

  modport slave (
    input  tri_valid_i, v0x_i, v0y_i, v1x_i, v1y_i, v2x_i, v2y_i, busy_i,
    output busy_o, area_o,
    output dl_w0_col_o, dl_w1_col_o, dl_w2_col_o,
    output dl_w0_row_o, dl_w1_row_o, dl_w2_row_o,
    output w0_row_o, w1_row_o, w2_row_o,
    output x_min_o, y_min_o, x_max_o, y_max_o,
    output valid_o, culled_o
  );

  modport master (
    output tri_valid_i, v0x_i, v0y_i, v1x_i, v1y_i, v2x_i, v2y_i, busy_i,
    input  busy_o, area_o,
    input  dl_w0_col_o, dl_w1_col_o, dl_w2_col_o,
    input  dl_w0_row_o, dl_w1_row_o, dl_w2_row_o,
    input  w0_row_o, w1_row_o, w2_row_o,
    input  x_min_o, y_min_o, x_max_o, y_max_o,
    input  valid_o, culled_o
  );
endinterface

// File: rtl/tri_setup.sv
// rtl/tri_setup.sv - triangle setup: area, bounding box and edge equations for a rasteriser
module tri_setup (
  input  logic       clock_i,
  input  logic       reset_i,
  tri_setup_if.slave bus
);

  typedef enum logic [2:0] {IDLE, AREA, EDGE0, EDGE1, EDGE2, SEND} state_t;

  state_t             state, state_next;
  logic [15:0]        v0x, v0y, v1x, v1y, v2x, v2y;
  logic [23:0]        area_w;
  logic [11:0]        bx_min, by_min, bx_max, by_max;
  logic signed [24:0] w0_w, w1_w;
  logic               ovf, ready;
  logic               accept, cull, load, xfer;

  function automatic logic signed [16:0] sub17(input logic [15:0] a, input logic [15:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [15:0] min3(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [15:0] max3(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One edge evaluator shared by the area pass and the three edge passes
  logic [15:0] ax, ay, bx, by, px, py;
  always_comb begin
    ax = v0x; ay = v0y; bx = v1x; by = v1y; px = v2x; py = v2y;
    case (state)
      EDGE0: begin
        ax = v1x; ay = v1y; bx = v2x; by = v2y; px = {bx_min, 4'h0}; py = {by_min, 4'h0};
      end
      EDGE1: begin
        ax = v2x; ay = v2y; bx = v0x; by = v0y; px = {bx_min, 4'h0}; py = {by_min, 4'h0};
      end
      EDGE2: begin
        ax = v0x; ay = v0y; bx = v1x; by = v1y; px = {bx_min, 4'h0}; py = {by_min, 4'h0};
      end
      default: ;
    endcase
  end

  logic signed [16:0] d_py, d_bx, d_px, d_by;
  logic signed [33:0] m0, m1;
  logic signed [34:0] e_raw, e;
  assign d_py  = sub17(py, ay);
  assign d_bx  = sub17(bx, ax);
  assign d_px  = sub17(px, ax);
  assign d_by  = sub17(by, ay);
  assign m0    = 34'(d_py) * 34'(d_bx);
  assign m1    = 34'(d_px) * 34'(d_by);
  assign e_raw = 35'(m0) - 35'(m1);
  assign e     = e_raw >>> 4;

  logic [15:0]        mn_x, mn_y, mx_x, mx_y;
  logic [12:0]        lo_x, lo_y, hi_x, hi_y;
  logic signed [34:0] area_abs;
  logic               area_bad, box_bad, e_ovf;
  assign mn_x     = min3(v0x, v1x, v2x);
  assign mn_y     = min3(v0y, v1y, v2y);
  assign mx_x     = max3(v0x, v1x, v2x);
  assign mx_y     = max3(v0y, v1y, v2y);
  assign lo_x     = 13'(({1'b0, mn_x} + 17'd15) >> 4);
  assign lo_y     = 13'(({1'b0, mn_y} + 17'd15) >> 4);
  assign hi_x     = 13'(mx_x >> 4);
  assign hi_y     = 13'(mx_y >> 4);
  assign area_abs = e[34] ? -e : e;
  assign area_bad = (e == '0) || (area_abs[34:24] != '0);
  assign box_bad  = (lo_x > hi_x) || (lo_y > hi_y) || lo_x[12] || lo_y[12];
  assign e_ovf    = (e[34:24] != {11{e[24]}});
  assign xfer     = (state == SEND) && ready;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cull       = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: if (bus.tri_valid_i) begin
        accept     = 1'b1;
        state_next = AREA;
      end
      AREA: if (area_bad || box_bad) begin
        cull       = 1'b1;
        state_next = IDLE;
      end else begin
        state_next = EDGE0;
      end
      EDGE0: state_next = EDGE1;
      EDGE1: state_next = EDGE2;
      EDGE2: if (ovf || e_ovf) begin
        cull       = 1'b1;
        state_next = IDLE;
      end else begin
        load       = 1'b1;
        state_next = SEND;
      end
      SEND: if (ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.valid_o = (state == SEND);
  assign bus.busy_o  = (state != IDLE);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state        <= IDLE;
      ready        <= 1'b1;
      ovf          <= 1'b0;
      bus.culled_o <= 1'b0;
    end else begin
      state        <= state_next;
      bus.culled_o <= cull;
      // Clear wins over set when a transfer coincides with busy_i low
      if (xfer)             ready <= 1'b0;
      else if (!bus.busy_i) ready <= 1'b1;
      if (accept)                                 ovf <= 1'b0;
      else if (state == EDGE0 || state == EDGE1)  ovf <= ovf | e_ovf;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      {v0x, v0y, v1x, v1y, v2x, v2y} <= '0;
      area_w <= '0;
      {bx_min, by_min, bx_max, by_max} <= '0;
      w0_w   <= '0;
      w1_w   <= '0;
    end else begin
      if (accept) begin
        v0x <= bus.v0x_i; v0y <= bus.v0y_i;
        v1x <= bus.v1x_i; v1y <= bus.v1y_i;
        v2x <= bus.v2x_i; v2y <= bus.v2y_i;
      end
      if (state == AREA) begin
        area_w <= area_abs[23:0];
        bx_min <= lo_x[11:0];
        by_min <= lo_y[11:0];
        bx_max <= hi_x[11:0];
        by_max <= hi_y[11:0];
        // Clockwise winding: swap v1/v2 so all edge functions stay positive inside
        if (e[34]) begin
          v1x <= v2x; v1y <= v2y;
          v2x <= v1x; v2y <= v1y;
        end
      end
      if (state == EDGE0) w0_w <= e[24:0];
      if (state == EDGE1) w1_w <= e[24:0];
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      bus.area_o      <= '0;
      bus.x_min_o     <= '0;
      bus.y_min_o     <= '0;
      bus.x_max_o     <= '0;
      bus.y_max_o     <= '0;
      bus.w0_row_o    <= '0;
      bus.w1_row_o    <= '0;
      bus.w2_row_o    <= '0;
      bus.dl_w0_col_o <= '0;
      bus.dl_w1_col_o <= '0;
      bus.dl_w2_col_o <= '0;
      bus.dl_w0_row_o <= '0;
      bus.dl_w1_row_o <= '0;
      bus.dl_w2_row_o <= '0;
    end else if (load) begin
      bus.area_o      <= area_w;
      bus.x_min_o     <= bx_min;
      bus.y_min_o     <= by_min;
      bus.x_max_o     <= bx_max;
      bus.y_max_o     <= by_max;
      bus.w0_row_o    <= w0_w;
      bus.w1_row_o    <= w1_w;
      bus.w2_row_o    <= e[24:0];
      bus.dl_w0_col_o <= sub17(v1y, v2y);
      bus.dl_w1_col_o <= sub17(v2y, v0y);
      bus.dl_w2_col_o <= sub17(v0y, v1y);
      bus.dl_w0_row_o <= sub17(v2x, v1x);
      bus.dl_w1_row_o <= sub17(v0x, v2x);
      bus.dl_w2_row_o <= sub17(v1x, v0x);
    end
  end

endmodule

// File: tb/tb_tri_setup.sv
// tb/tb_tri_setup.sv - directed self-checking bench for tri_setup
module tb_tri_setup;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  tri_setup_if bus();

  tri_setup dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a triangle in an IDLE cycle (T); returns in cycle T+1
  task automatic send_tri(input logic [15:0] ax, input logic [15:0] ay, input logic [15:0] bx,
                          input logic [15:0] by, input logic [15:0] cx, input logic [15:0] cy);
    bus.v0x_i = ax; bus.v0y_i = ay;
    bus.v1x_i = bx; bus.v1y_i = by;
    bus.v2x_i = cx; bus.v2y_i = cy;
    bus.tri_valid_i = 1'b1;
    tick();
    bus.tri_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.tri_valid_i = 1'b0;
    bus.busy_i = 1'b0;
    {bus.v0x_i, bus.v0y_i, bus.v1x_i, bus.v1y_i, bus.v2x_i, bus.v2y_i} = '0;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.valid_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy_o); end
    checks++; if (bus.culled_o !== 1'b0) begin errors++; $display("FAIL reset_culled: got %0b want 0", bus.culled_o); end
    checks++; if ({bus.area_o, bus.w0_row_o, bus.x_max_o, bus.dl_w0_col_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got area=%h w0=%h xmax=%h dlc0=%h want all 0",
                         bus.area_o, bus.w0_row_o, bus.x_max_o, bus.dl_w0_col_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    send_tri(16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0040);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_t1: got %0b want 1", bus.busy_o); end
    tick(); tick(); tick();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_t4: got %0b want 0", bus.valid_o); end
    tick();
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid_t5: got %0b want 1", bus.valid_o); end
    checks++; if (bus.area_o !== 24'h000100) begin errors++; $display("FAIL basic_area: got %h want 000100", bus.area_o); end
    checks++; if ({bus.x_min_o, bus.x_max_o, bus.y_min_o, bus.y_max_o} !== {12'd0, 12'd4, 12'd0, 12'd4}) begin
      errors++; $display("FAIL basic_box: got x %0d..%0d y %0d..%0d want x 0..4 y 0..4",
                         bus.x_min_o, bus.x_max_o, bus.y_min_o, bus.y_max_o);
    end
    checks++; if ({bus.w0_row_o, bus.w1_row_o, bus.w2_row_o} !== {25'sh100, 25'sh0, 25'sh0}) begin
      errors++; $display("FAIL basic_w: got %h %h %h want 100 0 0", bus.w0_row_o, bus.w1_row_o, bus.w2_row_o);
    end
    checks++; if ({bus.dl_w0_col_o, bus.dl_w1_col_o, bus.dl_w2_col_o} !== {-17'sd64, 17'sd64, 17'sd0}) begin
      errors++; $display("FAIL basic_dl_col: got %0d %0d %0d want -64 64 0",
                         bus.dl_w0_col_o, bus.dl_w1_col_o, bus.dl_w2_col_o);
    end
    checks++; if ({bus.dl_w0_row_o, bus.dl_w1_row_o, bus.dl_w2_row_o} !== {-17'sd64, 17'sd0, 17'sd64}) begin
      errors++; $display("FAIL basic_dl_row: got %0d %0d %0d want -64 0 64",
                         bus.dl_w0_row_o, bus.dl_w1_row_o, bus.dl_w2_row_o);
    end
    tick();
    checks++; if ({bus.valid_o, bus.busy_o} !== 2'b00) begin
      errors++; $display("FAIL basic_after_xfer: got valid=%0b busy=%0b want 0 0", bus.valid_o, bus.busy_o);
    end
  endtask

  task automatic test_cull(input string name, input logic [15:0] ax, input logic [15:0] ay,
                           input logic [15:0] bx, input logic [15:0] by,
                           input logic [15:0] cx, input logic [15:0] cy);
    send_tri(ax, ay, bx, by, cx, cy);
    checks++; if (bus.culled_o !== 1'b0) begin errors++; $display("FAIL %s_culled_t1: got %0b want 0", name, bus.culled_o); end
    tick();
    checks++; if ({bus.culled_o, bus.valid_o, bus.busy_o} !== 3'b100) begin
      errors++; $display("FAIL %s_t2: got culled=%0b valid=%0b busy=%0b want 1 0 0",
                         name, bus.culled_o, bus.valid_o, bus.busy_o);
    end
    tick();
    checks++; if ({bus.culled_o, bus.valid_o} !== 2'b00) begin
      errors++; $display("FAIL %s_t3: got culled=%0b valid=%0b want 0 0", name, bus.culled_o, bus.valid_o);
    end
    checks++; if (bus.area_o !== 24'h000100) begin errors++; $display("FAIL %s_hold_area: got %h want 000100", name, bus.area_o); end
    tick(); tick(); tick();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL %s_valid_late: got %0b want 0", name, bus.valid_o); end
  endtask

  task automatic test_back_to_back();
    bus.busy_i = 1'b1;
    send_tri(16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0040);
    tick(); tick(); tick(); tick();
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %0b want 1", bus.valid_o); end
    tick();
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL b2b_first_xfer: got %0b want 0", bus.valid_o); end
    send_tri(16'h0018, 16'h0008, 16'h0058, 16'h0008, 16'h0018, 16'h0048);
    tick(); tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid_%0d: got %0b want 1", i, bus.valid_o); end
      checks++; if ({bus.w0_row_o, bus.w1_row_o, bus.w2_row_o} !== {25'sh0C0, 25'sh020, 25'sh020}) begin
        errors++; $display("FAIL b2b_hold_w_%0d: got %h %h %h want 0c0 020 020",
                           i, bus.w0_row_o, bus.w1_row_o, bus.w2_row_o);
      end
      tick();
    end
    checks++; if ({bus.x_min_o, bus.x_max_o, bus.y_min_o, bus.y_max_o} !== {12'd2, 12'd5, 12'd1, 12'd4}) begin
      errors++; $display("FAIL b2b_box: got x %0d..%0d y %0d..%0d want x 2..5 y 1..4",
                         bus.x_min_o, bus.x_max_o, bus.y_min_o, bus.y_max_o);
    end
    bus.busy_i = 1'b0;
    tick();
    bus.busy_i = 1'b1;
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL b2b_ready_cycle: got %0b want 1", bus.valid_o); end
    tick();
    checks++; if ({bus.valid_o, bus.busy_o} !== 2'b00) begin
      errors++; $display("FAIL b2b_second_xfer: got valid=%0b busy=%0b want 0 0", bus.valid_o, bus.busy_o);
    end
    bus.busy_i = 1'b0;
    tick();
  endtask

  task automatic test_swap();
    send_tri(16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0040, 16'h0000);
    tick(); tick(); tick(); tick();
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL swap_valid: got %0b want 1", bus.valid_o); end
    checks++; if ({bus.area_o, bus.x_min_o, bus.x_max_o, bus.y_min_o, bus.y_max_o} !==
                  {24'h000100, 12'd0, 12'd4, 12'd0, 12'd4}) begin
      errors++; $display("FAIL swap_area_box: got area=%h x %0d..%0d y %0d..%0d want 000100 0..4 0..4",
                         bus.area_o, bus.x_min_o, bus.x_max_o, bus.y_min_o, bus.y_max_o);
    end
    checks++; if ({bus.w0_row_o, bus.w1_row_o, bus.w2_row_o} !== {25'sh100, 25'sh0, 25'sh0}) begin
      errors++; $display("FAIL swap_w: got %h %h %h want 100 0 0", bus.w0_row_o, bus.w1_row_o, bus.w2_row_o);
    end
    checks++; if ({bus.dl_w0_col_o, bus.dl_w1_col_o, bus.dl_w2_col_o,
                   bus.dl_w0_row_o, bus.dl_w1_row_o, bus.dl_w2_row_o} !==
                  {-17'sd64, 17'sd64, 17'sd0, -17'sd64, 17'sd0, 17'sd64}) begin
      errors++; $display("FAIL swap_dl: got col %0d %0d %0d row %0d %0d %0d want -64 64 0 / -64 0 64",
                         bus.dl_w0_col_o, bus.dl_w1_col_o, bus.dl_w2_col_o,
                         bus.dl_w0_row_o, bus.dl_w1_row_o, bus.dl_w2_row_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    send_tri(16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0040);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.valid_o, bus.busy_o, bus.culled_o} !== 3'b000) begin
      errors++; $display("FAIL rmid_flags: got valid=%0b busy=%0b culled=%0b want 0 0 0",
                         bus.valid_o, bus.busy_o, bus.culled_o);
    end
    checks++; if ({bus.area_o, bus.w0_row_o, bus.x_max_o, bus.y_max_o} !== '0) begin
      errors++; $display("FAIL rmid_outputs: got area=%h w0=%h xmax=%h ymax=%h want all 0",
                         bus.area_o, bus.w0_row_o, bus.x_max_o, bus.y_max_o);
    end
    tick(); tick();
    checks++; if (bus.culled_o !== 1'b0) begin errors++; $display("FAIL rmid_culled_hold: got %0b want 0", bus.culled_o); end
    rst_n = 1'b1;
    send_tri(16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0040);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL rmid_accept: got busy=%0b want 1", bus.busy_o); end
    tick(); tick(); tick(); tick();
    checks++; if ({bus.valid_o, bus.area_o} !== {1'b1, 24'h000100}) begin
      errors++; $display("FAIL rmid_result: got valid=%0b area=%h want 1 000100", bus.valid_o, bus.area_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cull("collinear", 16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0080, 16'h0000);
    test_cull("bigarea",   16'h0000, 16'h0000, 16'hFFF0, 16'h0000, 16'h0000, 16'hFFF0);
    test_cull("emptybox",  16'h0011, 16'h0011, 16'h001F, 16'h0012, 16'h0013, 16'h001F);
    test_back_to_back();
    test_swap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
